// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared constants and types for the instruction-fetch stage.
//            XLEN       - datapath width
//            NOP_INSTR  - canonical NOP (addi x0,x0,0) used to scrub IF/ID
//            fetch_state_t - BOOT / RUN / HALT control states
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int unsigned       XLEN      = 32;
  localparam logic [XLEN-1:0]   NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_if
// Purpose  : Bundles the fetch stage's memory, redirect and IF/ID signals.
//   imem_addr/imem_instr       : combinational instruction-memory port
//   redirect_valid/redirect_pc : PC change request from execute
//   id_valid/id_ready          : IF/ID handshake; id_instr/id_pc payload
//   fetch_err                  : sticky misaligned-redirect fault
//   fetch_count                : handshake counter (FETCH_PERF_CNT_EN only)
// Modports : master = fetch_unit side, slave = surrounding pipeline/memory.
// Config   : FETCH_PERF_CNT_EN adds fetch_count.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_if;
  import fetch_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_instr;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_ready;
  logic            id_valid;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic            fetch_err;
`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] fetch_count;
`endif

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    input  id_ready,
    output id_valid,
    output id_instr,
    output id_pc,
    output fetch_err
`ifdef FETCH_PERF_CNT_EN
    , output fetch_count
`endif
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    output id_ready,
    input  id_valid,
    input  id_instr,
    input  id_pc,
    input  fetch_err
`ifdef FETCH_PERF_CNT_EN
    , input fetch_count
`endif
  );

endinterface : fetch_if
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage. Owns the PC, drives the instruction
//            memory address straight from the PC register, and captures the
//            returned word into an IF/ID register with valid/ready toward
//            decode. Redirects from execute flush the in-flight instruction;
//            a misaligned redirect target halts the stage until reset.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            bus    - fetch_if.master (memory, redirect, IF/ID, status)
// Params   : RESET_PC - first fetch address after reset
// Config   : FETCH_PERF_CNT_EN - adds the 32-bit fetch_count counter/port
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic clk,
  input  wire logic rst_n,
  fetch_if.master   bus
);

  fetch_state_t    r_state,    w_state_next;
  logic [XLEN-1:0] r_pc,       w_pc_next;
  logic            r_id_valid, w_id_valid_next;
  logic [XLEN-1:0] r_id_instr, w_id_instr_next;
  logic [XLEN-1:0] r_id_pc,    w_id_pc_next;
  logic            r_err,      w_err_next;

  logic w_misaligned;
  logic w_adv;

  assign w_misaligned = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  // IF/ID slot may be refilled when empty or when decode is taking it now.
  assign w_adv        = !r_id_valid || bus.id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
      r_id_pc    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_id_valid <= w_id_valid_next;
      r_id_instr <= w_id_instr_next;
      r_id_pc    <= w_id_pc_next;
      r_err      <= w_err_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_id_valid_next = r_id_valid;
    w_id_instr_next = r_id_instr;
    w_id_pc_next    = r_id_pc;
    w_err_next      = r_err;

    case (r_state)
      BOOT, RUN: begin
        if (w_misaligned) begin
          // PC is deliberately left pointing at the last good address.
          w_id_valid_next = 1'b0;
          w_err_next      = 1'b1;
          w_state_next    = HALT;
        end else if (bus.redirect_valid) begin
          w_pc_next       = bus.redirect_pc;
          w_id_valid_next = 1'b0;
          w_id_instr_next = NOP_INSTR;
          w_state_next    = RUN;
        end else if (r_state == BOOT) begin
          w_state_next    = RUN;
        end else if (w_adv) begin
          w_id_instr_next = bus.imem_instr;
          w_id_pc_next    = r_pc;
          w_id_valid_next = 1'b1;
          w_pc_next       = r_pc + 32'd4;  // wraps modulo 2^32
        end
      end
      HALT: begin
        w_id_valid_next = 1'b0;
      end
      default: begin
        w_state_next    = HALT;
        w_id_valid_next = 1'b0;
      end
    endcase
  end

  assign bus.imem_addr = r_pc;
  assign bus.id_valid  = r_id_valid;
  assign bus.id_instr  = r_id_instr;
  assign bus.id_pc     = r_id_pc;
  assign bus.fetch_err = r_err;

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] r_fetch_count;

  // A handshake squashed by a same-cycle redirect is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (r_id_valid && bus.id_ready && !bus.redirect_valid) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign bus.fetch_count = r_fetch_count;
`endif

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit. A behavioural
//            instruction memory returns a distinct word per address.
// Config   : FETCH_PERF_CNT_EN enables the fetch_count scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  fetch_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'hC0DE};
  endfunction

  assign bus.imem_instr = mem_word(bus.imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b1;
    #17;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b1;
    #13;
    vectors++; if (bus.id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_id_valid got=%0b exp=0", bus.id_valid); end
    vectors++; if (bus.id_instr !== NOP_INSTR) begin miscompares++; $display("FAIL reset_id_instr got=%h exp=%h", bus.id_instr, NOP_INSTR); end
    vectors++; if (bus.id_pc !== 32'h0) begin miscompares++; $display("FAIL reset_id_pc got=%h exp=0", bus.id_pc); end
    vectors++; if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_imem_addr got=%h exp=0", bus.imem_addr); end
    vectors++; if (bus.fetch_err !== 1'b0) begin miscompares++; $display("FAIL reset_fetch_err got=%0b exp=0", bus.fetch_err); end
`ifdef FETCH_PERF_CNT_EN
    vectors++; if (bus.fetch_count !== 32'h0) begin miscompares++; $display("FAIL reset_fetch_count got=%0d exp=0", bus.fetch_count); end
`endif
  endtask

  task automatic test_streaming();
    logic [31:0] exp_pc;
    do_reset();
    tick();  // BOOT cycle
    vectors++; if (bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL boot_cycle valid=%0b addr=%h exp valid=0 addr=0", bus.id_valid, bus.imem_addr); end
    exp_pc = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (bus.id_valid !== 1'b1 || bus.id_pc !== exp_pc || bus.id_instr !== mem_word(exp_pc) || bus.imem_addr !== exp_pc + 32'd4) begin
        miscompares++;
        $display("FAIL stream_%0d valid=%0b pc=%h instr=%h addr=%h exp valid=1 pc=%h instr=%h addr=%h",
                 i, bus.id_valid, bus.id_pc, bus.id_instr, bus.imem_addr, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick(); tick(); tick();  // id_pc = 0x8 now
    vectors++; if (bus.id_pc !== 32'h8 || bus.imem_addr !== 32'hC) begin miscompares++; $display("FAIL stall_setup pc=%h addr=%h exp pc=8 addr=c", bus.id_pc, bus.imem_addr); end
    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h8 || bus.id_instr !== 32'h0008C0DE || bus.imem_addr !== 32'hC) begin
        miscompares++;
        $display("FAIL stall_hold_%0d valid=%0b pc=%h instr=%h addr=%h exp 1/8/0008c0de/c", i, bus.id_valid, bus.id_pc, bus.id_instr, bus.imem_addr);
      end
    end
    bus.id_ready = 1'b1;
    tick();
    vectors++; if (bus.id_pc !== 32'hC || bus.id_instr !== 32'h000CC0DE || bus.imem_addr !== 32'h10) begin miscompares++; $display("FAIL stall_release pc=%h instr=%h addr=%h exp c/000cc0de/10", bus.id_pc, bus.id_instr, bus.imem_addr); end
  endtask

  task automatic test_redirect_stall();
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    tick();
    bus.redirect_valid = 1'b0;
    vectors++; if (bus.id_valid !== 1'b0 || bus.id_instr !== NOP_INSTR || bus.imem_addr !== 32'h40) begin miscompares++; $display("FAIL redirect_flush valid=%0b instr=%h addr=%h exp 0/00000013/40", bus.id_valid, bus.id_instr, bus.imem_addr); end
    tick();
    vectors++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h40 || bus.id_instr !== 32'h0040C0DE || bus.imem_addr !== 32'h44) begin miscompares++; $display("FAIL redirect_target valid=%0b pc=%h instr=%h addr=%h exp 1/40/0040c0de/44", bus.id_valid, bus.id_pc, bus.id_instr, bus.imem_addr); end
    bus.id_ready = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    vectors++; if (bus.imem_addr !== 32'hFFFF_FFFC || bus.id_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_redirect addr=%h valid=%0b exp fffffffc/0", bus.imem_addr, bus.id_valid); end
    tick();
    vectors++; if (bus.id_pc !== 32'hFFFF_FFFC || bus.id_instr !== 32'hFFFCC0DE || bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_top pc=%h instr=%h addr=%h exp fffffffc/fffcc0de/0", bus.id_pc, bus.id_instr, bus.imem_addr); end
    tick();
    vectors++; if (bus.id_pc !== 32'h0 || bus.id_instr !== 32'h0000C0DE || bus.imem_addr !== 32'h4) begin miscompares++; $display("FAIL wrap_zero pc=%h instr=%h addr=%h exp 0/0000c0de/4", bus.id_pc, bus.id_instr, bus.imem_addr); end
  endtask

  task automatic test_misaligned();
    logic [31:0] held_addr;
    held_addr          = bus.imem_addr;  // 0x4 after the wrap scenario
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h42;
    tick();
    vectors++; if (bus.fetch_err !== 1'b1 || bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h4) begin miscompares++; $display("FAIL misalign_fault err=%0b valid=%0b addr=%h exp 1/0/4", bus.fetch_err, bus.id_valid, bus.imem_addr); end
    // Halted stage must ignore aligned redirects and handshakes.
    bus.redirect_pc = 32'h80;
    for (int i = 0; i < 3; i++) begin
      bus.id_ready = i[0];
      tick();
      bus.redirect_valid = 1'b0;
      vectors++;
      if (bus.fetch_err !== 1'b1 || bus.id_valid !== 1'b0 || bus.imem_addr !== held_addr) begin
        miscompares++;
        $display("FAIL halt_hold_%0d err=%0b valid=%0b addr=%h exp 1/0/%h", i, bus.fetch_err, bus.id_valid, bus.imem_addr, held_addr);
      end
    end
    // Async reset asserted between clock edges clears the fault at once.
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.fetch_err !== 1'b0 || bus.imem_addr !== 32'h0 || bus.id_instr !== NOP_INSTR) begin miscompares++; $display("FAIL async_clear err=%0b addr=%h instr=%h exp 0/0/00000013", bus.fetch_err, bus.imem_addr, bus.id_instr); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    tick(); tick(); tick();
    bus.id_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.id_valid !== 1'b0 || bus.id_pc !== 32'h0 || bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mid_stall valid=%0b pc=%h addr=%h exp 0/0/0", bus.id_valid, bus.id_pc, bus.imem_addr); end
    @(negedge clk);
    rst_n        = 1'b1;
    bus.id_ready = 1'b1;
    tick();
    tick();
    vectors++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0 || bus.imem_addr !== 32'h4) begin miscompares++; $display("FAIL restart_after_reset valid=%0b pc=%h addr=%h exp 1/0/4", bus.id_valid, bus.id_pc, bus.imem_addr); end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_counter();
    do_reset();
    tick(); tick();  // first instruction now valid
    for (int i = 0; i < 5; i++) tick();
    vectors++; if (bus.fetch_count !== 32'd5) begin miscompares++; $display("FAIL count_5 got=%0d exp=5", bus.fetch_count); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    tick();
    bus.redirect_valid = 1'b0;
    vectors++; if (bus.fetch_count !== 32'd5) begin miscompares++; $display("FAIL count_redirect got=%0d exp=5", bus.fetch_count); end
    bus.id_ready = 1'b0;
    tick(); tick();
    vectors++; if (bus.fetch_count !== 32'd5) begin miscompares++; $display("FAIL count_stall got=%0d exp=5", bus.fetch_count); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_streaming();
    test_stall();
    test_redirect_stall();
    test_wrap();
    test_misaligned();
    test_reset_mid_stall();
`ifdef FETCH_PERF_CNT_EN
    test_counter();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly upstream of `instr_mem`. It owns the program counter and drives `instr_mem`'s combinational `addr` port. It registers the returned `instr` into an IF/ID pipeline register with a valid/ready handshake toward decode. It also accepts branch/jump redirects from execute, flushing the in-flight instruction.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_addr`  out  32  fetch address to `instr_mem.addr`; always equals PC register
- `imem_instr`  in  32  combinational word from `instr_mem.instr`
- `redirect_valid`  in  1  execute requests PC change this cycle
- `redirect_pc`  in  32  redirect target
- `id_ready`  in  1  decode can accept `id_*` this cycle
- `id_valid`  out  1  `id_instr`/`id_pc` hold a valid instruction
- `id_instr`  out  32  registered instruction
- `id_pc`  out  32  address of `id_instr`
- `fetch_err`  out  1  sticky misaligned-redirect fault
- `fetch_count`  out  32  instructions handed to decode (only with `FETCH_PERF_CNT_EN`)

## Operation
- FSM states are BOOT, RUN and HALT.
- **Reset (async):**
  - state=BOOT, pc=RESET_PC
  - id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=0
  - fetch_err=0, fetch_count=0
- **BOOT:** one idle cycle, id_valid stays 0, then unconditionally → RUN.
  - A redirect in BOOT loads pc=redirect_pc and goes → RUN.
  - A misaligned redirect in BOOT goes → HALT.
- **RUN, advance condition:** `adv = !id_valid || id_ready`.
- **RUN, no redirect, adv=1:**
  - id_instr←imem_instr, id_pc←pc, id_valid←1, pc←pc+4
  - pc+4 wraps modulo 2^32: 0xFFFF_FFFC → 0x0000_0000.
- **RUN, no redirect, adv=0 (stall):** pc and all `id_*` hold.
- **RUN, redirect_valid=1 (priority over stall and advance):**
  - pc←redirect_pc, id_valid←0, id_instr←NOP
  - The instruction being handed over that cycle is dropped, not counted.
- **Misaligned redirect** (`redirect_pc[1:0]!=0`, any state except HALT):
  - pc unchanged, id_valid←0, fetch_err←1, → HALT.
- **HALT:** pc frozen, id_valid=0, inputs ignored; exit only via rst_n.
- **fetch_count:** increments by 1 on every cycle with `id_valid && id_ready && !redirect_valid`; wraps at 2^32.

## Timing
- `imem_addr` is a pure register output; no combinational path from any input to it.
- Latency: pc=A at edge n gives id_instr=mem[A], id_valid=1 after edge n+1.
- After rst_n deasserts: first id_valid=1 at the 2nd rising edge (BOOT + 1 fetch).
- Redirect at edge n: id_valid=0 after edge n; target instruction valid after edge n+1.
- Throughput: 1 instr/cycle with id_ready held high.
- id_* are stable while `id_valid && !id_ready` and no redirect (AXI-style hold).
- rst_n asserted mid-stall or mid-redirect: all outputs go to reset values immediately (async), with no pending state retained.

## Configuration
- `FETCH_PERF_CNT_EN` defined: the `fetch_count` port and its 32-bit counter exist, behaving as described above.
- `FETCH_PERF_CNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `fetch_pkg` holds:
  - `XLEN=32`
  - `NOP_INSTR=32'h0000_0013`
  - `fetch_state_t` enum {BOOT, RUN, HALT}
- No sub-module is needed: PC register, IF/ID register and FSM stay in one file. `instr_mem` is instantiated by the parent, not inside `fetch_unit`.

## Test plan
- **Reset/streaming:** instr_mem preloaded at 0x0..0x10; id_ready=1; release rst_n. Expect imem_addr=0x0 then 0x4, 0x8, …; id_valid first high at the 2nd edge; id_pc sequence 0x0, 0x4, 0x8, 0xC, 0x10 with matching words.
- **Stall:** id_ready=0 for 3 cycles while id_pc=0x8. Expect id_pc=0x8, id_instr and imem_addr=0xC held for all 3 cycles; id_pc=0xC one edge after id_ready=1.
- **Redirect with stall:** redirect_valid=1, redirect_pc=0x40, id_ready=0. Expect next cycle id_valid=0, id_instr=NOP, imem_addr=0x40; the cycle after, id_pc=0x40.
- **Wrap-around:** redirect to 0xFFFF_FFFC. Expect next imem_addr=0x0000_0000, with id_pc=0xFFFF_FFFC then 0x0.
- **Misaligned redirect:** redirect_pc=0x42. Expect fetch_err=1 and id_valid=0 permanently; imem_addr unchanged; cleared only by rst_n low.
- **Counter (`FETCH_PERF_CNT_EN`):** 5 handshakes then a redirect on the 6th. Expect fetch_count=5.
